// File: rtl/sel_encoder.sv
// ALU select encoder: mux-control requests -> 4-bit opcodes via FIFO + output stage.
// Optional saturating illegal-request counter under SEL_ENC_ERRCNT_EN.
module sel_encoder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sel2,
  input  logic [1:0] in_sel3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_select,
  output logic       err_pulse
`ifdef SEL_ENC_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACTIVE = 2'b01;
  localparam logic [1:0] S_FULL   = 2'b10;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic          r_out_valid;
  logic [3:0]    r_out_select;
  logic          r_err;

  logic          w_out_load;
  logic          w_fifo_empty;
  logic          w_pop;
  logic          w_acc;
  logic          w_illegal;
  logic          w_push;
  logic          w_bypass;
  logic          w_wr;
  logic [CW-1:0] w_count_nxt;
  logic          w_ovalid_nxt;
  logic [1:0]    w_state_nxt;
  logic [3:0]    w_enc;

  assign w_out_load   = !r_out_valid || out_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_pop        = w_out_load && !w_fifo_empty;
  assign in_ready     = !rst && ((r_state != S_FULL) || w_pop);
  assign w_acc        = in_valid && in_ready;
  assign w_illegal    = in_sel3[0];
  assign w_push       = w_acc && !w_illegal;
  // Empty FIFO with a free output stage: skip the FIFO entirely
  assign w_bypass     = w_push && w_fifo_empty && w_out_load;
  assign w_wr         = w_push && !w_bypass;

  assign w_count_nxt  = r_count + CW'(w_wr) - CW'(w_pop);
  assign w_ovalid_nxt = w_out_load ? (w_pop || w_bypass) : r_out_valid;

  always_comb begin
    w_enc = 4'b0000;
    unique case ({in_sel2, in_sel3[1]})
      2'b00: w_enc = 4'b0100;
      2'b11: w_enc = 4'b0010;
      2'b01: w_enc = 4'b0011;
      2'b10: w_enc = 4'b0001;
      default: w_enc = 4'b0000;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_push) w_state_nxt = S_ACTIVE;
      end
      (r_state == S_ACTIVE): begin
        if (w_count_nxt == LP_FULL)
          w_state_nxt = S_FULL;
        else if (!w_ovalid_nxt && w_count_nxt == '0)
          w_state_nxt = S_IDLE;
      end
      (r_state == S_FULL): begin
        if (w_pop && !w_wr) w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_enc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_out_select <= 4'b0000;
      r_err        <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count     <= w_count_nxt;
      r_state     <= w_state_nxt;
      r_out_valid <= w_ovalid_nxt;
      if (w_out_load) begin
        if (w_pop)
          r_out_select <= r_mem[r_rptr];
        else if (w_bypass)
          r_out_select <= w_enc;
      end
      r_err <= w_acc && w_illegal;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_select = r_out_select;
  assign err_pulse  = r_err;

`ifdef SEL_ENC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err_cnt <= 8'h00;
    else if (r_err && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_sel_encoder.sv
// Directed self-checking bench for sel_encoder (DEPTH=4).
// Exercises encoding, backpressure, FIFO full push+pop, illegal requests, reset.
module tb_sel_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel2;
  logic [1:0] in_sel3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_select;
  logic       err_pulse;
`ifdef SEL_ENC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sel_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel2    (in_sel2),
    .in_sel3    (in_sel3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_select (out_select),
    .err_pulse  (err_pulse)
`ifdef SEL_ENC_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s2, input logic [1:0] s3);
    in_valid = v;
    in_sel2  = s2;
    in_sel3  = s3;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel2   = 1'b0;
    in_sel3   = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || out_select !== 4'b0000 || err_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: valid=%b sel=%h err=%b want 0/0/0",
               out_valid, out_select, err_pulse);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
`ifdef SEL_ENC_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'h00) begin
      n_err++;
      $display("FAIL reset_err_count: got %h want 00", err_count);
    end
`endif
    do_reset();
  endtask

  task automatic test_encode();
    logic       s2 [4];
    logic [1:0] s3 [4];
    logic [3:0] ex [4];
    s2 = '{1'b0, 1'b1, 1'b0, 1'b1};
    s3 = '{2'b00, 2'b10, 2'b10, 2'b00};
    ex = '{4'h4, 4'h2, 4'h3, 4'h1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s2[i], s3[i]);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL enc_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_select !== ex[i]) begin
        n_err++;
        $display("FAIL enc[%0d]: valid=%b sel=%h want 1/%h",
                 i, out_valid, out_select, ex[i]);
      end
    end
    drive(1'b0, 1'b0, 2'b00);
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL enc_idle: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_full();
    logic       s2 [5];
    logic [1:0] s3 [5];
    logic [3:0] ex [5];
    s2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    s3 = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    ex = '{4'h4, 4'h2, 4'h3, 4'h1, 4'h4};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s2[i], s3[i]);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL full_push_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
    end
    drive(1'b1, 1'b1, 2'b00);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    tick();
    tick();
    drive(1'b0, 1'b0, 2'b00);
    n_vec++;
    if (out_valid !== 1'b1 || out_select !== 4'h4) begin
      n_err++;
      $display("FAIL full_hold: valid=%b sel=%h want 1/4", out_valid, out_select);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_select !== ex[i]) begin
        n_err++;
        $display("FAIL full_drain[%0d]: valid=%b sel=%h want 1/%h",
                 i, out_valid, out_select, ex[i]);
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_drain_end: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b01);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ill_ready: got %b want 1", in_ready);
    end
    tick();
    n_vec++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ill_first: err=%b valid=%b want 1/0", err_pulse, out_valid);
    end
    drive(1'b1, 1'b1, 2'b11);
    tick();
    n_vec++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ill_second: err=%b valid=%b want 1/0", err_pulse, out_valid);
    end
    drive(1'b0, 1'b0, 2'b00);
    tick();
    n_vec++;
    if (err_pulse !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ill_after: err=%b valid=%b want 0/0", err_pulse, out_valid);
    end
`ifdef SEL_ENC_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'h02) begin
      n_err++;
      $display("FAIL ill_count: got %h want 02", err_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b00);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_select !== 4'h4) begin
      n_err++;
      $display("FAIL b2b_0: valid=%b sel=%h want 1/4", out_valid, out_select);
    end
    drive(1'b1, 1'b0, 2'b11);
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || err_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_1: valid=%b err=%b want 0/1", out_valid, err_pulse);
    end
    drive(1'b1, 1'b1, 2'b10);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_select !== 4'h2 || err_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_2: valid=%b sel=%h err=%b want 1/2/0",
               out_valid, out_select, err_pulse);
    end
    drive(1'b0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_full_pushpop();
    logic       s2 [5];
    logic [1:0] s3 [5];
    logic [3:0] ex [5];
    s2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    s3 = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
    ex = '{4'h2, 4'h3, 4'h1, 4'h3, 4'h1};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s2[i], s3[i]);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b00);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pp_ready: got %b want 1", in_ready);
    end
    tick();
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pp_still_full: in_ready=%b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_select !== ex[i]) begin
        n_err++;
        $display("FAIL pp_drain[%0d]: valid=%b sel=%h want 1/%h",
                 i, out_valid, out_select, ex[i]);
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pp_drain_end: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'b10);
      tick();
    end
    drive(1'b0, 1'b0, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_select !== 4'h0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async: valid=%b sel=%h rdy=%b want 0/0/0",
               out_valid, out_select, in_ready);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b00);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_select !== 4'h1) begin
      n_err++;
      $display("FAIL rmid_first: valid=%b sel=%h want 1/1", out_valid, out_select);
    end
    drive(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_flushed[%0d]: valid=%b sel=%h want 0",
                 i, out_valid, out_select);
      end
    end
  endtask

`ifdef SEL_ENC_ERRCNT_EN
  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 254; i++) tick();
    drive(1'b0, 1'b0, 2'b00);
    tick();
    n_vec++;
    if (err_count !== 8'hFE) begin
      n_err++;
      $display("FAIL sat_254: got %h want FE", err_count);
    end
    drive(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 46; i++) tick();
    drive(1'b0, 1'b0, 2'b00);
    tick();
    tick();
    n_vec++;
    if (err_count !== 8'hFF) begin
      n_err++;
      $display("FAIL sat_300: got %h want FF", err_count);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel2   = 1'b0;
    in_sel3   = 2'b00;
    out_ready = 1'b0;
    test_reset();
    test_encode();
    test_full();
    test_illegal();
    test_back_to_back();
    test_full_pushpop();
    test_reset_mid();
`ifdef SEL_ENC_ERRCNT_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sel_encoder.md
SEL_ENCODER -- requirements
Module: sel_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a mux-control request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port in_sel2, input, 1 bit: 2:1 mux control (0 = B, 1 = zero).
REQ-007 SHALL have port in_sel3, input, 2 bits: 3:1 mux control (00 = A, 10 = -A; 01 and 11 illegal).
REQ-008 SHALL have port out_valid, output, 1 bit: out_select holds a valid opcode.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream decoder consumes the opcode.
REQ-010 SHALL have port out_select, output, 4 bits: the encoded ALU select opcode.
REQ-011 SHALL have port err_pulse, output, 1 bit: one-cycle pulse when an illegal request is accepted.
REQ-012 SHALL have port err_count, output, 8 bits: the saturating illegal-request count; the port exists only under SEL_ENC_ERRCNT_EN.

Function
REQ-013 SHALL encode each request as follows: (sel2=0, sel3=00) -> 4'b0100 ADD; (1, 10) -> 4'b0010 NEG; (0, 10) -> 4'b0011 SUB; (1, 00) -> 4'b0001 PASS.
REQ-014 SHALL accept a request on in_valid && in_ready; in_ready SHALL be high when the FIFO count < DEPTH, or when the count = DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL treat any request with sel3 = 01 or 11 as illegal: the request is accepted (consumes a handshake), is not written to the FIFO, and err_pulse is asserted in the following cycle.
REQ-016 SHALL write legal opcodes into a DEPTH-entry circular FIFO; read and write pointers wrap modulo DEPTH; the count ranges 0..DEPTH.
REQ-017 SHALL register the output through a one-entry output stage: out_valid/out_select update only when out_valid=0 or out_ready=1 (standard valid/ready).
REQ-018 SHALL hold out_select stable while out_valid=1 and out_ready=0.
REQ-019 SHALL give a minimum latency of 1 cycle from an accepted legal request on an empty block to out_valid=1; full throughput is 1 opcode per cycle.
REQ-020 SHALL, on a simultaneous push and pop with the count at DEPTH, accept the push and leave the count unchanged.
REQ-021 SHALL, on a simultaneous push and pop with the count at 0 and the output stage draining, bypass the FIFO into the output stage.
REQ-022 SHALL implement a control FSM with states IDLE (empty, out_valid=0), ACTIVE (data present), and FULL (count = DEPTH, in_ready=0 unless popping). Transitions: IDLE->ACTIVE on a legal push; ACTIVE->FULL when the count reaches DEPTH; FULL->ACTIVE on a pop without a push; ACTIVE->IDLE when the last entry is consumed with no push.
REQ-023 SHALL preserve order: opcodes leave in acceptance order, with illegal requests omitted.

Reset
REQ-024 SHALL, on rst=1, asynchronously clear the pointers and count, enter IDLE, and force out_valid=0, out_select=4'b0000, err_pulse=0, and err_count=0; in_ready SHALL be 0 while rst=1.
REQ-025 SHALL discard all buffered and in-flight requests on a reset asserted mid-operation; the first accepted request after reset release yields the first output.

Configuration
REQ-026 SHALL, with macro SEL_ENC_ERRCNT_EN defined, provide err_count, incrementing on each err_pulse and saturating at 8'hFF.
REQ-027 SHALL, without SEL_ENC_ERRCNT_EN, omit both the err_count port and its counter; err_pulse remains.

Verification
REQ-028 SHALL pass this scenario: after reset, send (0,00),(1,10),(0,10),(1,00) with out_ready=1 -> out_select = 4, 2, 3, 1 on consecutive cycles, with the first one 1 cycle after the first accept.
REQ-029 SHALL pass this scenario: hold out_ready=0 and push 5 legal requests with DEPTH=4 -> the FSM enters FULL and in_ready=0 after the output stage plus 4 entries are filled, and out_select is held; then release out_ready -> all requests drain in order.
REQ-030 SHALL pass this scenario: push (0,01) then (1,11) -> two err_pulse cycles, no out_valid, and err_count=2 (with the macro).
REQ-031 SHALL pass this scenario: with the FIFO full, assert push and pop in the same cycle -> the push is accepted, the count stays at 4, and the order is preserved.
REQ-032 SHALL pass this scenario: assert rst mid-burst with 3 entries pending -> out_valid=0 immediately; after release, a push of (1,00) -> out_select=4'b0001 only.
REQ-033 SHALL pass this scenario: 300 illegal requests with the macro defined -> err_count saturates at 8'hFF.
